// File: rtl/adder_sched.sv
// Round-robin scheduler that shares one external N/2-bit adder among NREQ requesters.
// Define ADD_SCHED_RR_EN for round-robin arbitration; otherwise lowest index wins.
module adder_sched #(
    parameter int unsigned N    = 64,
    parameter int unsigned NREQ = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*N-1:0]         req_a,
    input  logic [NREQ*N-1:0]         req_b,
    output logic [N/2-1:0]            add_a,
    output logic [N/2-1:0]            add_b,
    output logic                      add_cin,
    input  logic [N/2-1:0]            add_sum,
    input  logic                      add_cout,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [N-1:0]              rsp_sum,
    output logic                      rsp_cout
);

    localparam int unsigned M  = N / 2;
    localparam int unsigned IW = $clog2(NREQ);

    typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    a_q, b_q;
    logic [IW-1:0]   grant_q;
    logic            carry_q;
    logic [M-1:0]    sum_lo_q;
    logic            rsp_valid_q;
    logic [N-1:0]    rsp_sum_q;
    logic            rsp_cout_q;
    logic [IW-1:0]   rsp_id_q;

    logic            any_valid;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   cand;
    int unsigned     search_base;
    logic            accept;

    assign accept = (state_q == StIdle) && any_valid;

`ifdef ADD_SCHED_RR_EN
    logic [IW-1:0] last_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= IW'(NREQ - 1);
        end else if (accept) begin
            last_q <= winner;
        end
    end

    assign search_base = 32'(last_q) + 32'd1;
`else
    assign search_base = 32'd0;
`endif

    // Search upward from search_base with wrap; the first valid index found wins.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IW'((search_base + k) % NREQ);
            if (!any_valid && req_valid[cand]) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        unique case (state_q)
            StIdle: if (any_valid) state_d = StLow;
            StLow: begin
                add_a   = a_q[M-1:0];
                add_b   = b_q[M-1:0];
                state_d = StHigh;
            end
            StHigh: begin
                add_a   = a_q[N-1:M];
                add_b   = b_q[N-1:M];
                add_cin = carry_q;
                state_d = StDone;
            end
            StDone: if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            grant_q     <= '0;
            carry_q     <= 1'b0;
            sum_lo_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        a_q     <= req_a[winner*N +: N];
                        b_q     <= req_b[winner*N +: N];
                        grant_q <= winner;
                    end
                end
                StLow: begin
                    sum_lo_q <= add_sum;
                    carry_q  <= add_cout;
                end
                StHigh: begin
                    rsp_sum_q   <= {add_sum, sum_lo_q};
                    rsp_cout_q  <= add_cout;
                    rsp_id_q    <= grant_q;
                    rsp_valid_q <= 1'b1;
                end
                StDone: if (rsp_ready) rsp_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_adder_sched.sv
// Scoreboard bench for adder_sched: a transaction-level model predicts grants and sums,
// a separate monitor pops expected responses on each rsp handshake.
module tb_adder_sched;

    localparam int N    = 64;
    localparam int NREQ = 4;
    localparam int M    = N / 2;
    localparam int IW   = $clog2(NREQ);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*N-1:0]    req_a, req_b;
    logic [M-1:0]         add_a, add_b, add_sum;
    logic                 add_cin, add_cout;
    logic                 rsp_valid, rsp_ready;
    logic [IW-1:0]        rsp_id;
    logic [N-1:0]         rsp_sum;
    logic                 rsp_cout;

    adder_sched #(.N(N), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    // External half-width adder
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{M{1'b0}}, add_cin};

    always #5 clk = ~clk;

    typedef struct {
        int           id;
        logic [N-1:0] sum;
        logic         cout;
    } exp_t;

    exp_t exp_q[$];
    int   seen_ids[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_acc = 0, n_rsp = 0, n_flushed = 0;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int last);
`ifdef ADD_SCHED_RR_EN
        for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
`else
        for (int k = 0; k < NREQ; k++) if (v[k]) return k;
`endif
        return -1;
    endfunction

    // Transaction model: idle -> accept, two adder cycles, then hold until consumed
    int              m_phase = 0;
    int              m_last  = NREQ - 1;
    int              m_win;
    logic [N-1:0]    m_a, m_b;
    logic [N:0]      m_full;
    logic [M:0]      m_lo;
    logic [NREQ-1:0] e_ready;
    logic [M-1:0]    e_add_a, e_add_b;
    logic            e_cin;

    always @(negedge clk) begin
        if (!rst) begin
            check("reset_rsp_valid", rsp_valid, 0);
            check("reset_rsp_sum", rsp_sum, 0);
            check("reset_rsp_cout", rsp_cout, 0);
            check("reset_rsp_id", rsp_id, 0);
            check("reset_req_ready", req_ready, 0);
            check("reset_add", {add_cin, add_a, add_b}, 0);
            m_phase = 0;
            m_last = NREQ - 1;
            n_flushed += exp_q.size();
            exp_q.delete();
        end else begin
            m_win = pick(req_valid, m_last);
            e_ready = '0;
            if (m_phase == 0 && m_win >= 0) e_ready = NREQ'(1) << m_win;
            check("req_ready", req_ready, e_ready);
            e_add_a = '0;
            e_add_b = '0;
            e_cin = 1'b0;
            m_lo = {1'b0, m_a[M-1:0]} + {1'b0, m_b[M-1:0]};
            if (m_phase == 1) begin
                e_add_a = m_a[M-1:0];
                e_add_b = m_b[M-1:0];
            end else if (m_phase == 2) begin
                e_add_a = m_a[N-1:M];
                e_add_b = m_b[N-1:M];
                e_cin = m_lo[M];
            end
            check("add_a", add_a, e_add_a);
            check("add_b", add_b, e_add_b);
            check("add_cin", add_cin, e_cin);
            check("rsp_valid", rsp_valid, (m_phase == 3));
            case (m_phase)
                0: if (m_win >= 0) begin
                    m_a = req_a[m_win*N +: N];
                    m_b = req_b[m_win*N +: N];
                    m_full = {1'b0, m_a} + {1'b0, m_b};
                    exp_q.push_back('{id: m_win, sum: m_full[N-1:0], cout: m_full[N]});
                    m_last = m_win;
                    n_acc++;
                    m_phase = 1;
                end
                1: m_phase = 2;
                2: m_phase = 3;
                default: if (rsp_ready) m_phase = 0;
            endcase
        end
    end

    // Monitor: compares the presented response every cycle it is valid, pops on handshake
    always @(negedge clk) begin
        if (rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                check("rsp_id", rsp_id, exp_q[0].id);
                check("rsp_sum", rsp_sum, exp_q[0].sum);
                check("rsp_cout", rsp_cout, exp_q[0].cout);
                if (rsp_ready) begin
                    seen_ids.push_back(int'(rsp_id));
                    void'(exp_q.pop_front());
                    n_rsp++;
                end
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
    endtask

    function automatic logic [N-1:0] rnd_op();
        case ($urandom_range(0, 3))
            0: return '1;
            1: return {32'h0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    int exp_order[5];

    initial begin
`ifdef ADD_SCHED_RR_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        rst = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        cyc(3);
        rst = 1'b1;

        // Idle quiet
        cyc(10);

        // Contention from reset
        for (int i = 0; i < NREQ; i++) set_op(i, rnd_op(), rnd_op());
        seen_ids.delete();
        req_valid = '1;
        cyc(24);
        req_valid = '0;
        cyc(6);
        check("grant_count", (seen_ids.size() >= 5), 1);
        if (seen_ids.size() >= 5)
            for (int i = 0; i < 5; i++) check("grant_order", seen_ids[i], exp_order[i]);

        // Single request with carry across halves
        set_op(0, 64'h0000_0000_FFFF_FFFF, 64'h1);
        req_valid = 4'b0001;
        cyc(1);
        req_valid = '0;
        cyc(6);

        // Full wrap
        set_op(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
        req_valid = 4'b0100;
        cyc(1);
        req_valid = '0;
        cyc(6);

        // Backpressure with requester 1 waiting
        set_op(1, rnd_op(), rnd_op());
        req_valid = 4'b0010;
        cyc(1);
        rsp_ready = 1'b0;
        cyc(8);
        rsp_ready = 1'b1;
        cyc(2);
        req_valid = '0;
        cyc(6);

        // Reset during HIGH, then a fresh request
        set_op(3, rnd_op(), rnd_op());
        req_valid = 4'b1000;
        cyc(2);
        rst = 1'b0;
        req_valid = '0;
        cyc(2);
        rst = 1'b1;
        cyc(1);
        set_op(3, 64'd5, 64'd7);
        req_valid = 4'b1000;
        cyc(1);
        req_valid = '0;
        cyc(6);

        // Randomised traffic
        for (int c = 0; c < 400; c++) begin
            req_valid = NREQ'($urandom) & NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) set_op(i, rnd_op(), rnd_op());
            rsp_ready = ($urandom_range(0, 3) != 0);
            cyc(1);
        end

        req_valid = '0;
        rsp_ready = 1'b1;
        cyc(10);
        check("queue_empty", exp_q.size(), 0);
        check("rsp_count", n_rsp, n_acc - n_flushed);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

endmodule
